// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron datapath blocks.
package nn_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        LOAD,
        FETCH,
        FIRE,
        WAIT,
        EMIT
    } feeder_state_e;

    // Clamp a signed 16-bit result to zero when enabled and negative.
    function automatic word_t relu16(input word_t v, input logic en);
        return (en && v[15]) ? '0 : v;
    endfunction

endpackage

// File: rtl/mac_feeder.sv
// Producer side of the neuron MAC interface: collects one pixel frame, then
// for each neuron streams its weight row and bias out of memory, strobes the
// MAC once, captures the result (optionally ReLU-clamped) and emits it on a
// valid/ready stream.
module mac_feeder
    import nn_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = 784,
    parameter int unsigned NUM_NEURONS = 16,
    parameter int unsigned MAC_LATENCY = 1,
    parameter bit          RELU        = 1'b1,
    localparam int unsigned WAW = (NUM_NEURONS * INPUT_WIDTH > 1) ? $clog2(NUM_NEURONS * INPUT_WIDTH) : 1,
    localparam int unsigned NW  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    input  logic [15:0]                 pix_data,
    output logic [WAW-1:0]              w_addr,
    output logic                        w_rd_en,
    input  logic [15:0]                 w_data,
    output logic [NW-1:0]               b_addr,
    output logic                        b_rd_en,
    input  logic [15:0]                 b_data,
    output logic [INPUT_WIDTH*16-1:0]   mac_inputs,
    output logic [15:0]                 mac_weights [0:INPUT_WIDTH-1],
    output logic [15:0]                 mac_bias,
    output logic                        mac_valid,
    input  logic [15:0]                 mac_out,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [15:0]                 res_data,
    output logic [NW-1:0]               res_idx,
    output logic                        res_last,
    output logic                        busy
);

    localparam int unsigned PW = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
    localparam int unsigned KW = $clog2(INPUT_WIDTH + 1);
    localparam int unsigned LW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(INPUT_WIDTH - 1);
    localparam logic [KW-1:0] K_RLAST = KW'(INPUT_WIDTH - 1);
    localparam logic [KW-1:0] K_CAP   = KW'(INPUT_WIDTH);
    localparam logic [NW-1:0] N_LAST  = NW'(NUM_NEURONS - 1);
    localparam logic [LW-1:0] L_LAST  = LW'(MAC_LATENCY - 1);

    feeder_state_e   state_q;
    logic [PW-1:0]   p_q;
    logic [NW-1:0]   n_q;
    logic [KW-1:0]   k_q;
    logic [LW-1:0]   l_q;

    word_t           pix_q [0:INPUT_WIDTH-1];
    word_t           wt_q  [0:INPUT_WIDTH-1];
    word_t           bias_q;

    logic            pix_ready_q;
    logic            busy_q;
    logic [WAW-1:0]  w_addr_q;
    logic            w_rd_en_q;
    logic [NW-1:0]   b_addr_q;
    logic            b_rd_en_q;
    logic            mac_valid_q;
    logic            res_valid_q;
    word_t           res_data_q;
    logic [NW-1:0]   res_idx_q;
    logic            res_last_q;

    logic            pix_fire_d;
    logic [PW-1:0]   cap_idx_d;
    word_t           res_data_d;

    // Handshake, capture slot (one behind the read counter) and clamped result.
    always_comb begin
        pix_fire_d = pix_valid & pix_ready_q;
        cap_idx_d  = k_q[PW-1:0] - PW'(1);
        res_data_d = relu16(mac_out, RELU);
    end

    // Main sequencer: counters, memory strobes, MAC strobe and result stream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= LOAD;
            p_q         <= '0;
            n_q         <= '0;
            k_q         <= '0;
            l_q         <= '0;
            pix_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            w_addr_q    <= '0;
            w_rd_en_q   <= 1'b0;
            b_addr_q    <= '0;
            b_rd_en_q   <= 1'b0;
            mac_valid_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_last_q  <= 1'b0;
        end else begin
            mac_valid_q <= 1'b0;
            b_rd_en_q   <= 1'b0;
            case (state_q)
                LOAD: begin
                    pix_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    if (pix_fire_d) begin
                        if (p_q == P_LAST) begin
                            p_q         <= '0;
                            pix_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            n_q         <= '0;
                            k_q         <= '0;
                            w_rd_en_q   <= 1'b1;
                            w_addr_q    <= '0;
                            b_rd_en_q   <= 1'b1;
                            b_addr_q    <= '0;
                            state_q     <= FETCH;
                        end else begin
                            p_q <= p_q + PW'(1);
                        end
                    end
                end
                FETCH: begin
                    if (k_q == K_CAP) begin
                        mac_valid_q <= 1'b1;
                        state_q     <= FIRE;
                    end else begin
                        k_q <= k_q + KW'(1);
                        if (k_q == K_RLAST) begin
                            w_rd_en_q <= 1'b0;
                        end else begin
                            w_addr_q <= w_addr_q + WAW'(1);
                        end
                    end
                end
                FIRE: begin
                    l_q     <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (l_q == L_LAST) begin
                        res_data_q  <= res_data_d;
                        res_idx_q   <= n_q;
                        res_last_q  <= (n_q == N_LAST);
                        res_valid_q <= 1'b1;
                        state_q     <= EMIT;
                    end else begin
                        l_q <= l_q + LW'(1);
                    end
                end
                EMIT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (res_last_q) begin
                            p_q         <= '0;
                            pix_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= LOAD;
                        end else begin
                            // The previous row ended at n*W+W-1, so the next
                            // row starts one address further on; this keeps
                            // w_addr a plain counter instead of n*W+k.
                            n_q       <= n_q + NW'(1);
                            k_q       <= '0;
                            w_rd_en_q <= 1'b1;
                            w_addr_q  <= w_addr_q + WAW'(1);
                            b_rd_en_q <= 1'b1;
                            b_addr_q  <= n_q + NW'(1);
                            state_q   <= FETCH;
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    // Pixel frame storage, written one element per accepted transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned j = 0; j < INPUT_WIDTH; j++) begin
                pix_q[j] <= '0;
            end
        end else if (state_q == LOAD && pix_fire_d) begin
            pix_q[p_q] <= pix_data;
        end
    end

    // Weight row and bias capture, one cycle behind their read strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned j = 0; j < INPUT_WIDTH; j++) begin
                wt_q[j] <= '0;
            end
            bias_q <= '0;
        end else if (state_q == FETCH && k_q != '0) begin
            wt_q[cap_idx_d] <= w_data;
            if (k_q == KW'(1)) begin
                bias_q <= b_data;
            end
        end
    end

    for (genvar g = 0; g < INPUT_WIDTH; g++) begin : g_pack
        assign mac_inputs[g*16 +: 16] = pix_q[g];
    end

    assign mac_weights = wt_q;
    assign mac_bias    = bias_q;
    assign pix_ready   = pix_ready_q;
    assign busy        = busy_q;
    assign w_addr      = w_addr_q;
    assign w_rd_en     = w_rd_en_q;
    assign b_addr      = b_addr_q;
    assign b_rd_en     = b_rd_en_q;
    assign mac_valid   = mac_valid_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_idx     = res_idx_q;
    assign res_last    = res_last_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Scoreboard bench for mac_feeder: W=4, N=2, MAC_LATENCY=1, with a scripted
// MAC stub. A RELU=1 and a RELU=0 instance run in lockstep on shared inputs.
module tb_mac_feeder;
    import nn_pkg::*;

    localparam int unsigned W = 4;
    localparam int unsigned N = 2;
    localparam int unsigned L = 1;

    typedef struct {
        logic [15:0] d;
        logic [15:0] raw;
        logic        idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = '0;
    logic        res_ready = 1'b1;
    logic [15:0] w_data = '0;
    logic [15:0] b_data = '0;
    logic [15:0] mac_out = '0;

    logic        pix_ready, w_rd_en, b_rd_en, mac_valid, res_valid, res_last, busy;
    logic [2:0]  w_addr;
    logic [0:0]  b_addr, res_idx;
    logic [63:0] mac_inputs;
    logic [15:0] mac_weights [0:W-1];
    logic [15:0] mac_bias, res_data;

    logic        pix_ready_b, w_rd_en_b, b_rd_en_b, mac_valid_b, res_valid_b, res_last_b, busy_b;
    logic [2:0]  w_addr_b;
    logic [0:0]  b_addr_b, res_idx_b;
    logic [63:0] mac_inputs_b;
    logic [15:0] mac_weights_b [0:W-1];
    logic [15:0] mac_bias_b, res_data_b;

    logic [15:0] wmem [8] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
    logic [15:0] bmem [2] = '{16'd5, 16'd9};
    logic [15:0] script [2] = '{16'h1234, 16'h8001};

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    logic [63:0] frame_q [$];
    exp_t        res_q [$];

    always #5 clk = ~clk;

    mac_feeder #(.INPUT_WIDTH(W), .NUM_NEURONS(N), .MAC_LATENCY(L), .RELU(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .w_addr(w_addr), .w_rd_en(w_rd_en), .w_data(w_data),
        .b_addr(b_addr), .b_rd_en(b_rd_en), .b_data(b_data),
        .mac_inputs(mac_inputs), .mac_weights(mac_weights), .mac_bias(mac_bias),
        .mac_valid(mac_valid), .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_idx(res_idx), .res_last(res_last), .busy(busy)
    );

    mac_feeder #(.INPUT_WIDTH(W), .NUM_NEURONS(N), .MAC_LATENCY(L), .RELU(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .pix_valid(pix_valid), .pix_ready(pix_ready_b), .pix_data(pix_data),
        .w_addr(w_addr_b), .w_rd_en(w_rd_en_b), .w_data(w_data),
        .b_addr(b_addr_b), .b_rd_en(b_rd_en_b), .b_data(b_data),
        .mac_inputs(mac_inputs_b), .mac_weights(mac_weights_b), .mac_bias(mac_bias_b),
        .mac_valid(mac_valid_b), .mac_out(mac_out),
        .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_data_b),
        .res_idx(res_idx_b), .res_last(res_last_b), .busy(busy_b)
    );

    // Synchronous-read weight and bias memories.
    always @(posedge clk) begin
        if (w_rd_en) w_data <= wmem[w_addr];
        if (b_rd_en) b_data <= bmem[b_addr];
    end

    // MAC stub: returns the scripted value for each neuron one cycle after mac_valid.
    logic sidx;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sidx    <= 1'b0;
            mac_out <= '0;
        end else if (mac_valid) begin
            mac_out <= script[sidx];
            sidx    <= ~sidx;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic fail(input string nm);
        n_total++;
        $display("FAIL %s: bound expired or unexpected event", nm);
    endtask

    // Monitor: read-address model, MAC-strobe checks and result scoreboard.
    int unsigned ra_cnt = 0, bn_cnt = 0, fire_n = 0, mv_total = 0, last_total = 0;
    logic        prev_mv = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            ra_cnt  = 0;
            bn_cnt  = 0;
            fire_n  = 0;
            prev_mv = 1'b0;
        end else begin
            if (w_rd_en) begin
                chk("w_addr", 64'(w_addr), 64'(ra_cnt));
                chk("w_addr_b", 64'(w_addr_b), 64'(ra_cnt));
                chk("w_rd_en_b", 64'(w_rd_en_b), 64'(1));
                ra_cnt = (ra_cnt + 1) % (W * N);
            end
            if (b_rd_en) begin
                chk("b_addr", 64'(b_addr), 64'(bn_cnt));
                chk("b_addr_b", 64'(b_addr_b), 64'(bn_cnt));
                chk("b_rd_en_b", 64'(b_rd_en_b), 64'(1));
                bn_cnt = (bn_cnt + 1) % N;
            end
            if (mac_valid) begin
                chk("mac_valid_b2b", 64'(prev_mv), 64'(0));
                chk("mac_valid_b", 64'(mac_valid_b), 64'(1));
                mv_total++;
                if (frame_q.size() == 0) begin
                    fail("mac_valid_unexpected");
                end else begin
                    logic [2:0] wi;
                    chk("mac_inputs", mac_inputs, frame_q[0]);
                    chk("mac_inputs_b", mac_inputs_b, frame_q[0]);
                    for (int j = 0; j < W; j++) begin
                        wi = 3'(fire_n * W + j);
                        chk("mac_weights", 64'(mac_weights[j]), 64'(wmem[wi]));
                        chk("mac_weights_b", 64'(mac_weights_b[j]), 64'(wmem[wi]));
                    end
                    chk("mac_bias", 64'(mac_bias), 64'(bmem[fire_n[0]]));
                    chk("mac_bias_b", 64'(mac_bias_b), 64'(bmem[fire_n[0]]));
                    fire_n++;
                    if (fire_n == N) begin
                        fire_n = 0;
                        void'(frame_q.pop_front());
                    end
                end
            end
            prev_mv = mac_valid;
            if (res_valid && res_ready) begin
                if (res_q.size() == 0) begin
                    fail("res_unexpected");
                end else begin
                    exp_t e;
                    e = res_q.pop_front();
                    chk("res_data", 64'(res_data), 64'(e.d));
                    chk("res_idx", 64'(res_idx), 64'(e.idx));
                    chk("res_last", 64'(res_last), 64'(e.last));
                    chk("res_valid_b", 64'(res_valid_b), 64'(1));
                    chk("res_data_norelu", 64'(res_data_b), 64'(e.raw));
                    chk("res_idx_b", 64'(res_idx_b), 64'(e.idx));
                    chk("res_last_b", 64'(res_last_b), 64'(e.last));
                end
                if (res_last) last_total++;
            end
        end
    end

    // Feeds one frame using a pix_valid pattern (bits beyond plen are 1).
    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                              input logic [15:0] d, input logic [15:0] pat, input int unsigned plen);
        logic [15:0] px [4];
        logic [63:0] ev;
        int unsigned t, i, cy;
        logic        hs;
        px[0] = a; px[1] = b; px[2] = c; px[3] = d;
        ev = {d, c, b, a};
        frame_q.push_back(ev);
        res_q.push_back('{16'h1234, 16'h1234, 1'b0, 1'b0});
        res_q.push_back('{16'h0000, 16'h8001, 1'b1, 1'b1});
        t = 0;
        while (!pix_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!pix_ready) fail("pix_ready_timeout");
        i = 0; cy = 0;
        while (i < 4 && cy < 100) begin
            pix_valid = (cy < plen) ? pat[cy[3:0]] : 1'b1;
            pix_data  = pix_valid ? px[i[1:0]] : 16'hBEEF;
            @(negedge clk);
            hs = pix_valid && pix_ready;
            @(posedge clk); #1;
            if (hs) i++;
            cy++;
        end
        pix_valid = 1'b0;
        pix_data  = '0;
        if (i != 4) fail("pix_transfer_timeout");
        chk("pix_ready_drop", 64'(pix_ready), 64'(0));
        chk("pix_ready_drop_b", 64'(pix_ready_b), 64'(0));
        chk("busy_fetch", 64'(busy), 64'(1));
        chk("busy_fetch_b", 64'(busy_b), 64'(1));
        chk("fetch_start", 64'(w_rd_en), 64'(1));
        chk("mac_inputs_load", mac_inputs, ev);
    endtask

    task automatic wait_results();
        int unsigned t = 0;
        while (res_q.size() != 0 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (res_q.size() != 0) fail("res_timeout");
    endtask

    task automatic check_load_reentry();
        chk("load_pix_ready", 64'(pix_ready), 64'(1));
        chk("load_busy", 64'(busy), 64'(0));
        chk("load_res_valid", 64'(res_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned t, mv0, l0;

        // Reset state
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_pix_ready", 64'(pix_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_mac_valid", 64'(mac_valid), 64'(0));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_w_rd_en", 64'(w_rd_en), 64'(0));
        chk("rst_b_rd_en", 64'(b_rd_en), 64'(0));
        chk("rst_mac_inputs", mac_inputs, 64'(0));
        chk("rst_mac_bias", 64'(mac_bias), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_pix_ready_first", 64'(pix_ready), 64'(0));
        @(posedge clk); #1;
        chk("rst_pix_ready_after", 64'(pix_ready), 64'(1));

        // Frame with zero-valued pixels, continuous valid, results with and without ReLU
        send_frame(16'd1, 16'd0, 16'd3, 16'd0, 16'hFFFF, 4);
        chk("frame1_pack", mac_inputs, 64'h0000_0003_0000_0001);
        wait_results();
        check_load_reentry();

        // Backpressure on the first result
        res_ready = 1'b0;
        send_frame(16'd5, 16'd6, 16'd7, 16'd8, 16'hFFFF, 4);
        t = 0;
        while (!res_valid && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("bp_valid", 64'(res_valid), 64'(1));
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_valid_hold", 64'(res_valid), 64'(1));
            chk("bp_data_hold", 64'(res_data), 64'(16'h1234));
            chk("bp_idx_hold", 64'(res_idx), 64'(0));
            chk("bp_last_hold", 64'(res_last), 64'(0));
            chk("bp_no_fire", 64'(mac_valid), 64'(0));
            chk("bp_no_read", 64'(w_rd_en), 64'(0));
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_fetch_n1", 64'(w_rd_en), 64'(1));
        chk("bp_waddr_n1", 64'(w_addr), 64'(4));
        chk("bp_valid_drop", 64'(res_valid), 64'(0));
        wait_results();
        check_load_reentry();

        // Gapped pixel stream 1-0-0-1-1-0-1; gap cycles carry junk data
        send_frame(16'd9, 16'd0, 16'd0, 16'd2, 16'b0000_0000_0101_1001, 7);
        chk("gap_pack", mac_inputs, 64'h0002_0000_0000_0009);
        wait_results();
        check_load_reentry();

        // Reset during neuron 1 fetch abandons the frame
        send_frame(16'd1, 16'd2, 16'd3, 16'd4, 16'hFFFF, 4);
        t = 0;
        while (!(w_rd_en && w_addr == 3'd5) && t < 100) begin
            @(posedge clk); #1; t++;
        end
        chk("midrst_reached_n1", 64'(w_addr), 64'(5));
        reset_n = 1'b0;
        #1;
        chk("midrst_res_valid", 64'(res_valid), 64'(0));
        chk("midrst_w_rd_en", 64'(w_rd_en), 64'(0));
        chk("midrst_w_addr", 64'(w_addr), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_pix_ready", 64'(pix_ready), 64'(0));
        chk("midrst_mac_inputs", mac_inputs, 64'(0));
        chk("midrst_mac_bias", 64'(mac_bias), 64'(0));
        chk("midrst_mac_w0", 64'(mac_weights[0]), 64'(0));
        res_q.delete();
        frame_q.delete();
        @(negedge clk);
        chk("midrst_res_valid_held", 64'(res_valid), 64'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        send_frame(16'd4, 16'd3, 16'd2, 16'd1, 16'hFFFF, 4);
        wait_results();
        check_load_reentry();

        // Two back-to-back frames
        for (int f = 0; f < 2; f++) begin
            mv0 = mv_total;
            l0  = last_total;
            send_frame(16'(f + 16'h0100), 16'h7FFF, 16'hFFFF, 16'(f), 16'hFFFF, 4);
            wait_results();
            check_load_reentry();
            chk("mac_valid_per_frame", 64'(mv_total - mv0), 64'(2));
            chk("res_last_per_frame", 64'(last_total - l0), 64'(1));
        end

        repeat (3) begin @(posedge clk); #1; end
        chk("end_idle_mac_valid", 64'(mac_valid), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
Producer side of the neuron MAC interface. It accepts one input frame as a serial pixel stream and packs it into the flat MAC input vector. For each neuron in turn it reads that neuron's weight row and bias from on-chip memories, presents them to the MAC with a one-cycle valid pulse, captures mac_out, applies optional ReLU, and emits one result per neuron on a valid/ready stream. It sits between the pixel source and the layer's MAC, and one instance drives one layer.

Parameters:
INPUT_WIDTH, 784, number of 16-bit inputs per frame and weights per neuron
NUM_NEURONS, 16, neurons in the layer (results per frame)
MAC_LATENCY, 1, cycles from the mac_valid edge until mac_out is stable; must be >= 1
RELU, 1, 1: clamp negative results (bit 15 set) to 0; 0: pass through

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
pix_valid  in  1  pixel stream valid
pix_ready  out  1  pixel stream ready
pix_data  in  16  pixel value
w_addr  out  $clog2(NUM_NEURONS*INPUT_WIDTH)  weight memory read address
w_rd_en  out  1  weight read strobe
w_data  in  16  weight read data, valid 1 cycle after w_rd_en
b_addr  out  $clog2(NUM_NEURONS) (min 1)  bias memory read address
b_rd_en  out  1  bias read strobe
b_data  in  16  bias read data, valid 1 cycle after b_rd_en
mac_inputs  out  INPUT_WIDTH*16  packed input vector; element j at [j*16 +: 16]
mac_weights  out  16 x [0:INPUT_WIDTH-1]  unpacked weight array
mac_bias  out  16  bias for the current neuron
mac_valid  out  1  single-cycle compute strobe to the MAC
mac_out  in  16  MAC result
res_valid  out  1  result valid
res_ready  in  1  result ready
res_data  out  16  neuron result after optional ReLU
res_idx  out  $clog2(NUM_NEURONS) (min 1)  neuron index of res_data
res_last  out  1  high with the result of neuron NUM_NEURONS-1
busy  out  1  high in every state except LOAD

Behaviour:
- Reset (asynchronous, reset_n=0): state LOAD, pixel and neuron counters 0, and every output 0: mac_inputs, mac_weights, mac_bias, mac_valid, res_*, w_*, b_*, busy. pix_ready=1 one cycle after reset deasserts.
- Reset mid-operation abandons the frame and restarts at LOAD. No partial result is emitted.
- LOAD:
  - pix_ready=1. Each cycle with pix_valid & pix_ready writes pix_data to element p, then p increments.
  - The transfer with p==INPUT_WIDTH-1 moves to FETCH with n=0 and k=0.
  - pix_ready is 0 in all other states.
- FETCH, INPUT_WIDTH+1 cycles:
  - Cycles k=0..INPUT_WIDTH-1 assert w_rd_en with w_addr = n*INPUT_WIDTH + k.
  - Cycle k+1 writes w_data into mac_weights[k].
  - Cycle 0 also asserts b_rd_en with b_addr=n; cycle 1 loads b_data into mac_bias.
  - After the final capture cycle, go to FIRE.
- FIRE, 1 cycle: mac_valid=1, then go to WAIT.
- WAIT: lasts MAC_LATENCY cycles. On its last cycle, register mac_out into res_data and go to EMIT.
  - With RELU=1 and mac_out[15]=1, res_data=0.
- EMIT:
  - res_valid=1, res_idx=n, res_last=(n==NUM_NEURONS-1).
  - res_data, res_idx and res_last hold stable while res_ready=0.
  - On res_valid & res_ready: if last, go to LOAD (p=0); else n++ and go to FETCH.
  - Valid is never withdrawn without a handshake.
- Stability: mac_inputs, mac_weights and mac_bias do not change from the FIRE cycle through the end of WAIT. mac_inputs holds the frame until the next LOAD transfer.
- mac_valid is high exactly once per neuron; never two cycles back to back.
- Per-neuron cycle count with no backpressure: INPUT_WIDTH+1 (FETCH) + 1 (FIRE) + MAC_LATENCY (WAIT) + 1 (EMIT).
- Width rules:
  - Counters are sized $clog2 of their bound (minimum 1 bit).
  - w_addr is computed without truncation, so it reaches NUM_NEURONS*INPUT_WIDTH-1.
  - A pixel value of 0 is valid data and is still stored.

Decomposition:
- Shared package nn_pkg holds:
  - typedef word_t (logic [15:0]);
  - state enum feeder_state_e {LOAD, FETCH, FIRE, WAIT, EMIT};
  - function relu16.
- No sub-module. The FSM, counters and storage arrays stay flat in mac_feeder.

Test Plan:
Bench setup for every scenario: INPUT_WIDTH=4, NUM_NEURONS=2, MAC_LATENCY=1, and a behavioural MAC stub that returns a scripted mac_out.
1. Pixels 1,0,3,0 with continuous pix_valid -> mac_inputs==0x0000_0003_0000_0001 and pix_ready drops the cycle after the 4th transfer. Weight memory rows [10,20,30,40] and [50,60,70,80], biases 5 and 9 -> w_addr sequence 0,1,2,3 then 4,5,6,7; at the mac_valid pulses, mac_weights equals each row and mac_bias equals 5, then 9.
2. Stub returns 0x1234 then 0x8001 with RELU=1 -> results (0x1234, idx 0, last 0) and (0x0000, idx 1, last 1). With RELU=0 -> second result is 0x8001.
3. res_ready held low for 5 cycles in EMIT -> res_valid stays 1 with stable data, no new mac_valid or w_rd_en; one cycle after res_ready=1, FETCH for neuron 1 begins.
4. Gaps in pix_valid (1-0-0-1-1-0-1) -> exactly 4 pixels stored, in order; FETCH starts the cycle after the 4th handshake.
5. reset_n pulsed low during FETCH of neuron 1 -> all outputs 0 immediately, no res_valid; the next frame of 4 pixels produces a correct 2-result sequence starting at idx 0.
6. Two back-to-back frames -> exactly 2 mac_valid pulses per frame, res_last once per frame, and LOAD re-entered after each last handshake.
